// File: rtl/text_glyph_serializer_pkg.sv
// Shared constants and types for the text-mode glyph serializer.
package text_glyph_serializer_pkg;

  localparam int TEXT_AW  = 12;
  localparam int FONT_AW  = 12;
  localparam int CELL_W   = 8;
  localparam int CELL_H   = 16;

  // Attribute bit positions inside a text RAM word
  localparam int ATTR_R   = 10;
  localparam int ATTR_G   = 9;
  localparam int ATTR_B   = 8;

  // Clock edges from hcount/vcount sample to serial_output
  localparam int PIPE_LAT = 4;

  typedef struct packed {
    logic display_area;
    logic hsync;
    logic vsync;
  } sync_bits_t;

endpackage

// File: rtl/text_glyph_serializer_sync_delay_line.sv
// Fixed-depth shift register used to keep timing flags aligned with pixel data.
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the flags one stage per clock; reset clears every stage so no stale flag survives
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/text_glyph_serializer.sv
// Text-mode pixel source: text RAM fetch, font ROM fetch, bit select and cursor overlay.
module text_glyph_serializer
  import text_glyph_serializer_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               display_area_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [TEXT_AW-1:0] text_addr,
  input  logic [10:0]        text_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  input  logic               cursor_en,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  output logic               serial_output,
  output logic               Radd,
  output logic               Gadd,
  output logic               Badd,
  output logic               display_area,
  output logic               hsync,
  output logic               vsync
);

  logic [5:0] cell_row;
  logic [6:0] cell_col;

  // E1 stage
  logic [2:0] px_d1;
  logic [3:0] line_d1;
  logic [6:0] col_d1;
  logic [5:0] row_d1;
  logic       cen_d1;
  logic [6:0] ccol_d1;
  logic [4:0] crow_d1;

  // E2 stage
  logic [2:0] px_d2;
  logic [3:0] line_d2;
  logic       cur_d2;
  logic       cur_hit;

  // E3 stage
  logic [2:0] px_d3;
  logic       cur_d3;
  logic [2:0] attr_d3;
  sync_bits_t sync_d3;

  // Blink
  logic       frame_match;
  logic       match_d;
  logic       frame_tick;
  logic [7:0] blink_cnt;
  logic       blink_phase;

  logic       pix_bit;

  assign cell_row = vcount[9:4];
  assign cell_col = hcount[9:3];

  // E1: word address (wraps modulo the address width) and cell coordinates
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      text_addr <= '0;
      px_d1     <= '0;
      line_d1   <= '0;
      col_d1    <= '0;
      row_d1    <= '0;
      cen_d1    <= 1'b0;
      ccol_d1   <= '0;
      crow_d1   <= '0;
    end else begin
      text_addr <= 12'(cell_row) * 12'(COLS) + 12'(cell_col);
      px_d1     <= hcount[2:0];
      line_d1   <= vcount[3:0];
      col_d1    <= cell_col;
      row_d1    <= cell_row;
      cen_d1    <= cursor_en;
      ccol_d1   <= cursor_col;
      crow_d1   <= cursor_row;
    end
  end

  // Underline cursor occupies the bottom two glyph lines of the cursor cell
  assign cur_hit = cen_d1 & blink_phase & (col_d1 == ccol_d1) &
                   (row_d1 == {1'b0, crow_d1}) & (line_d1 >= 4'd14);

  // E2: carry pixel/line position and latch the cursor decision
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px_d2   <= '0;
      line_d2 <= '0;
      cur_d2  <= 1'b0;
    end else begin
      px_d2   <= px_d1;
      line_d2 <= line_d1;
      cur_d2  <= cur_hit;
    end
  end

  // Font address is formed straight from the RAM output; held at 0 in reset
  assign font_addr = reset_n ? {text_data[7:0], line_d2} : '0;

  // E3: capture the attribute while the font ROM fetches the glyph row
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px_d3   <= '0;
      cur_d3  <= 1'b0;
      attr_d3 <= '0;
    end else begin
      px_d3   <= px_d2;
      cur_d3  <= cur_d2;
      attr_d3 <= {text_data[ATTR_R], text_data[ATTR_G], text_data[ATTR_B]};
    end
  end

  sync_delay_line #(
    .WIDTH(3),
    .DEPTH(PIPE_LAT - 1)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .data    ({display_area_in, hsync_in, vsync_in}),
    .delayed (sync_d3)
  );

  assign pix_bit = font_data[3'd7 - px_d3];

  // E4: final pixel, colour select and aligned timing flags
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      serial_output <= 1'b0;
      Radd          <= 1'b0;
      Gadd          <= 1'b0;
      Badd          <= 1'b0;
      display_area  <= 1'b0;
      hsync         <= 1'b0;
      vsync         <= 1'b0;
    end else begin
      serial_output      <= sync_d3.display_area & (pix_bit | cur_d3);
      {Radd, Gadd, Badd} <= sync_d3.display_area ? attr_d3 : 3'b000;
      display_area       <= sync_d3.display_area;
      hsync              <= sync_d3.hsync;
      vsync              <= sync_d3.vsync;
    end
  end

  // Frame tick fires only on the first cycle the end-of-text position is seen
  assign frame_match = (vcount == 10'(ROWS * CELL_H)) && (hcount == '0);
  assign frame_tick  = frame_match & ~match_d;

  // Blink counter: toggles the cursor phase every BLINK_FRAMES frame ticks
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      match_d     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      match_d <= frame_match;
      if (frame_tick) begin
        if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_glyph_serializer.sv
// Bench for text_glyph_serializer: memory models, a sample-history reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_text_glyph_serializer;

  localparam int BF = 3;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hcount, vcount;
  logic        display_area_in, hsync_in, vsync_in;
  logic [11:0] text_addr;
  logic [10:0] text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        serial_output, Radd, Gadd, Badd;
  logic        display_area, hsync, vsync;

  int total = 0;
  int bad   = 0;

  logic [10:0] tmem [4096];
  logic [7:0]  fmem [4096];

  text_glyph_serializer #(
    .COLS(80), .ROWS(30), .BLINK_FRAMES(BF)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .hcount(hcount), .vcount(vcount),
    .display_area_in(display_area_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .serial_output(serial_output), .Radd(Radd), .Gadd(Gadd), .Badd(Badd),
    .display_area(display_area), .hsync(hsync), .vsync(vsync)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous RAM/ROM models: data valid one cycle after address
  always @(posedge vga_clk) begin
    text_data <= tmem[text_addr];
    font_data <= fmem[font_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] m_addr(input logic [9:0] h, input logic [9:0] v);
    int a;
    a = (int'(v) / 16) * 80 + int'(h) / 8;
    return 12'(a % 4096);
  endfunction

  // Reference model: history of sampled inputs, indexed by clock edge
  int          e = 8;
  int          m_ticks = 0;
  logic        m_prev = 1'b0;
  logic [9:0]  s_h [8];
  logic [9:0]  s_v [8];
  logic        s_da [8];
  logic        s_hs [8];
  logic        s_vs [8];
  logic        s_cen [8];
  logic [6:0]  s_cc [8];
  logic [4:0]  s_cr [8];
  logic        s_ph [8];

  always @(posedge vga_clk) begin : compare
    int idx, j, k, pi;
    logic [10:0] w;
    logic [7:0]  g;
    logic        hit, e_ser;
    logic [2:0]  e_rgb;
    #1;
    e++;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        s_da[i] = 1'b0; s_hs[i] = 1'b0; s_vs[i] = 1'b0;
      end
      m_ticks = 0;
      m_prev  = 1'b0;
      check("rst_pixel", {serial_output, Radd, Gadd, Badd}, 4'b0);
      check("rst_sync", {display_area, hsync, vsync}, 3'b0);
      check("rst_taddr", text_addr, 12'h0);
      check("rst_faddr", font_addr, 12'h0);
    end else begin
      idx = e % 8;
      if ((vcount == 10'd480) && (hcount == 10'd0)) begin
        if (!m_prev) m_ticks++;
        m_prev = 1'b1;
      end else begin
        m_prev = 1'b0;
      end
      s_h[idx] = hcount; s_v[idx] = vcount;
      s_da[idx] = display_area_in; s_hs[idx] = hsync_in; s_vs[idx] = vsync_in;
      s_cen[idx] = cursor_en; s_cc[idx] = cursor_col; s_cr[idx] = cursor_row;
      s_ph[idx] = ((m_ticks / BF) % 2) == 1;

      if (display_area_in) check("m_taddr", text_addr, m_addr(hcount, vcount));

      j = (e - 1) % 8;
      if (s_da[j]) begin
        w = tmem[m_addr(s_h[j], s_v[j])];
        check("m_faddr", font_addr, {w[7:0], s_v[j][3:0]});
      end

      k = (e - 3) % 8;
      e_ser = 1'b0;
      e_rgb = 3'b000;
      if (s_da[k]) begin
        w  = tmem[m_addr(s_h[k], s_v[k])];
        g  = fmem[{w[7:0], s_v[k][3:0]}];
        pi = 7 - int'(s_h[k][2:0]);
        hit = s_cen[k] && s_ph[k] && (int'(s_h[k]) / 8 == int'(s_cc[k])) &&
              (int'(s_v[k]) / 16 == int'(s_cr[k])) && (int'(s_v[k][3:0]) >= 14);
        e_ser = g[pi] | hit;
        e_rgb = w[10:8];
      end
      check("m_serial", serial_output, e_ser);
      check("m_rgb", {Radd, Gadd, Badd}, e_rgb);
      check("m_sync", {display_area, hsync, vsync}, {s_da[k], s_hs[k], s_vs[k]});
    end
  end

  task automatic cyc(input logic [9:0] h, input logic [9:0] v, input logic da,
                     input logic hs, input logic vs);
    @(negedge vga_clk);
    hcount = h; vcount = v; display_area_in = da; hsync_in = hs; vsync_in = vs;
  endtask

  logic exp_pix [8];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tmem[i] = 11'h0;
      fmem[i] = 8'h0;
    end
    tmem[0]    = 11'h541;  fmem[12'h410] = 8'b1000_0001;
    tmem[2399] = 11'h3A7;
    tmem[80]   = 11'h7FF;  fmem[12'hFF0] = 8'hFF;
    tmem[81]   = 11'h4C3;  fmem[12'hC30] = 8'hC0;
    tmem[164]  = 11'h220;  tmem[165] = 11'h220;  tmem[166] = 11'h220;
    exp_pix = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    hcount = '0; vcount = '0; display_area_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

    // Reset hold with active inputs: everything stays 0
    repeat (3) cyc(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    check("hold_serial", serial_output, 1'b0);
    check("hold_taddr", text_addr, 12'h0);
    check("hold_faddr", font_addr, 12'h0);
    check("hold_da", display_area, 1'b0);
    check("hold_hsync", hsync, 1'b0);

    // Release with pixel 0 of cell 0, then sweep the cell
    @(negedge vga_clk);
    reset_n = 1'b1;
    hcount = 10'd0; vcount = 10'd0; display_area_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    for (int i = 1; i < 12; i++) begin
      cyc(10'(i), 10'd0, 1'b1, 1'b0, 1'b0);
      if (i == 1) check("first_taddr", text_addr, 12'd0);
      if (i < 4) begin
        check("lat_da", display_area, 1'b0);
        check("lat_serial", serial_output, 1'b0);
      end else begin
        if (i == 4) check("first_da", display_area, 1'b1);
        check("cell0_serial", serial_output, exp_pix[i-4]);
        check("cell0_rgb", {Radd, Gadd, Badd}, 3'b101);
      end
    end

    // Last visible cell: address 2399 and glyph line 15
    cyc(10'd639, 10'd479, 1'b1, 1'b0, 1'b0);
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    check("last_taddr", text_addr, 12'd2399);
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    check("last_faddr", font_addr, 12'hA7F);
    repeat (4) cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

    // Solid glyph during blanking: pixel and colour forced off, syncs still delayed
    for (int i = 0; i < 12; i++) begin
      logic [3:0] p;
      p = 4'(i);
      cyc(10'(i % 8), 10'd16, 1'b0, p[0], p[1]);
      if (i >= 4) begin
        p = 4'(i - 4);
        check("blank_serial", serial_output, 1'b0);
        check("blank_rgb", {Radd, Gadd, Badd}, 3'b000);
        check("blank_sync", {hsync, vsync}, {p[0], p[1]});
      end
    end
    for (int i = 0; i < 8; i++) cyc(10'(i), 10'd16, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

    // Blinking underline cursor at column 5, row 2 over blank glyphs
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
    for (int f = 0; f <= 2 * BF; f++) begin
      for (int v = 45; v <= 47; v++)
        for (int h = 36; h <= 51; h++) cyc(10'(h), 10'(v), 1'b1, 1'b0, 1'b0);
      cyc(10'd40, 10'd46, 1'b1, 1'b0, 1'b0);
      repeat (4) cyc(10'd40, 10'd45, 1'b1, 1'b0, 1'b0);
      check("cursor_on_line14", serial_output, 1'(((f / BF) % 2) == 1));
      cyc(10'd40, 10'd45, 1'b1, 1'b0, 1'b0);
      check("cursor_off_line13", serial_output, 1'b0);
      cyc(10'd0, 10'd480, 1'b0, 1'b0, 1'b1);
      cyc(10'd0, 10'd480, 1'b0, 1'b0, 1'b1);
      cyc(10'd1, 10'd480, 1'b0, 1'b0, 1'b1);
    end
    cursor_en = 1'b0;

    // One-cycle reset in the middle of a line of solid pixels
    for (int i = 0; i < 6; i++) cyc(10'(i), 10'd16, 1'b1, 1'b1, 1'b0);
    @(negedge vga_clk);
    reset_n = 1'b0;
    #1;
    check("midrst_pixel", {serial_output, Radd, Gadd, Badd}, 4'b0);
    check("midrst_da", display_area, 1'b0);
    check("midrst_taddr", text_addr, 12'h0);
    check("midrst_blink_cnt", dut.blink_cnt, 8'd0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    hcount = 10'd8; vcount = 10'd16; display_area_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    for (int i = 1; i < 7; i++) begin
      cyc(10'(8 + i), 10'd16, 1'b1, 1'b0, 1'b0);
      if (i < 4) begin
        check("resume_da", display_area, 1'b0);
        check("resume_serial", serial_output, 1'b0);
      end
      if (i == 4) begin
        check("resume_da_on", display_area, 1'b1);
        check("resume_serial_on", serial_output, 1'b1);
        check("resume_rgb", {Radd, Gadd, Badd}, 3'b100);
      end
    end
    repeat (5) cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
